// File: rtl/div_unit_if.sv
// Operand/result bundle between the execute stage and the HI/LO divider.
// The master modport is the pipeline side; the slave modport is the divider.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic             isSigned;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  modport master (
    output start, isSigned, dividend, divisor, cancel,
    input  busy, done, divByZero, lo, hi
  );

  modport slave (
    input  start, isSigned, dividend, divisor, cancel,
    output busy, done, divByZero, lo, hi
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS div/divu: quotient on lo, remainder on hi.
// One quotient bit per cycle on operand magnitudes, then a single sign-fix cycle.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  div_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] dvnd_q, dvnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    dvnd_d  = dvnd_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    lo_d    = lo_q;
    hi_d    = hi_q;

    // {rem, quo} shifted left one place; trial subtract at WIDTH+1 bits
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvnd_d  = bus.dividend;
          zero_d  = (bus.divisor == '0);
          q_neg_d = bus.isSigned & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          r_neg_d = bus.isSigned & bus.dividend[WIDTH-1];
          quo_d   = (bus.isSigned && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
          dvsr_d  = (bus.isSigned && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.cancel) begin
          // divide by zero reports the raw dividend and skips sign correction
          if (zero_q) begin
            lo_d = quo_q;
            hi_d = dvnd_q;
          end else begin
            lo_d = q_neg_q ? -quo_q : quo_q;
            hi_d = r_neg_q ? -rem_q : rem_q;
          end
          dbz_d  = zero_q;
          done_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      dvnd_q  <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      dvnd_q  <= dvnd_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.divByZero = dbz_q;
  assign bus.lo        = lo_q;
  assign bus.hi        = hi_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected results are queued at issue and
// compared when done pulses; handshake, cancel and reset are checked inline.
module tb_div_unit;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    e.dbz = (b == '0);
    if (b == '0) begin
      e.lo = '1;
      e.hi = a;
    end else if (!s) begin
      e.lo = a / b;
      e.hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = '0;
    end else begin
      e.lo = $signed(a) / $signed(b);
      e.hi = $signed(a) % $signed(b);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; returns just after the sampling edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    bus.isSigned = s;
    if (push) sb.push_back(model(a, b, s));
    tick();
    bus.start    = 1'b0;
  endtask

  // Waits (bounded) for done; checks latency, busy width and result against the queue head.
  task automatic wait_result(input string tag, input int unsigned waited_already);
    int unsigned n;
    int unsigned busy_n;
    exp_t e;
    n      = waited_already;
    busy_n = waited_already;
    while (bus.done !== 1'b1 && n < 45) begin
      if (bus.busy === 1'b1) busy_n++;
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 33);
    check({tag, "_busy_cycles"}, busy_n, 33);
    check({tag, "_busy_at_done"}, {31'b0, bus.busy}, 0);
    if (sb.size() == 0) begin
      check({tag, "_queue_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_lo"}, bus.lo, e.lo);
      check({tag, "_hi"}, bus.hi, e.hi);
      check({tag, "_dbz"}, {31'b0, bus.divByZero}, {31'b0, e.dbz});
    end
  endtask

  task automatic done_drops(input string tag);
    tick();
    check({tag, "_done_pulse"}, {31'b0, bus.done}, 0);
  endtask

  initial begin
    int unsigned seen_done;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.isSigned = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.cancel   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_done", {31'b0, bus.done}, 0);
    check("rst_dbz",  {31'b0, bus.divByZero}, 0);
    check("rst_lo",   bus.lo, 0);
    check("rst_hi",   bus.hi, 0);

    // Unsigned basic; cancel asserted alongside start must not block it
    bus.cancel = 1'b1;
    issue(32'd222222, 32'd111111, 1'b0, 1'b1);
    bus.cancel = 1'b0;
    wait_result("divu_basic", 0);
    done_drops("divu_basic");

    // Sign rules and corners
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
    wait_result("div_7_m2", 0);
    done_drops("div_7_m2");
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    wait_result("div_m7_2", 0);
    done_drops("div_m7_2");
    issue(32'hFFFF_FFFF, 32'd16, 1'b0, 1'b1);
    wait_result("divu_max_16", 0);
    done_drops("divu_max_16");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_result("div_ovf", 0);
    done_drops("div_ovf");
    issue(32'd5, 32'd0, 1'b1, 1'b1);
    wait_result("div_by0", 0);
    done_drops("div_by0");
    issue(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1);
    wait_result("div_neg_by0", 0);
    done_drops("div_neg_by0");
    issue(32'h8765_4321, 32'h0001_2345, 1'b1, 1'b1);
    wait_result("div_rand", 0);
    done_drops("div_rand");

    // start while busy is ignored; re-issue in the done cycle
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    for (int i = 1; i < 9; i++) tick();
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    tick();
    bus.start    = 1'b0;
    wait_result("busy_start", 9);
    issue(32'd9, 32'd3, 1'b0, 1'b1);
    wait_result("b2b", 0);
    done_drops("b2b");

    // Cancel mid-operation after a 2/0 result
    issue(32'd222222, 32'd111111, 1'b0, 1'b1);
    wait_result("pre_cancel", 0);
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    for (int i = 1; i < 14; i++) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check("cancel_busy", {31'b0, bus.busy}, 0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) seen_done++;
      tick();
    end
    check("cancel_no_done", seen_done, 0);
    check("cancel_lo", bus.lo, 32'd2);
    check("cancel_hi", bus.hi, 32'd0);

    // Reset mid-operation, then a fresh operation
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    for (int i = 1; i < 14; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", {31'b0, bus.busy}, 0);
    check("midrst_done", {31'b0, bus.done}, 0);
    check("midrst_dbz",  {31'b0, bus.divByZero}, 0);
    check("midrst_lo",   bus.lo, 0);
    check("midrst_hi",   bus.hi, 0);
    issue(32'd222222, 32'd111111, 1'b0, 1'b1);
    wait_result("post_rst", 0);
    done_drops("post_rst");

    check("queue_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
